// File: rtl/controller_if.sv
// Output bundle of the AliSim sequence-evolution controller: branch index, alignment, P matrix.
// The master modport drives the bundle; the slave modport consumes it.
interface controller_if;
  logic [2:0]   pos;
  logic [31:0]  nucl_alig;
  logic [159:0] matrix_P;

  modport master (output pos, nucl_alig, matrix_P);
  modport slave  (input  pos, nucl_alig, matrix_P);
endinterface

// File: rtl/controller.sv
// Sequence-evolution engine: walks 8 branches, emits P per branch and resamples 16 sites from it.
// Optional macro CTRL_ROOT_RELOAD_EN: reload the root alignment on the 7 -> 0 wrap edge.
module controller #(
  parameter logic [31:0] ROOT_SEQ     = 32'h1B1B_1B1B,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001,
  parameter int unsigned OFFDIAG_STEP = 8
) (
  input logic          clk,
  input logic          reset,
  controller_if.master bus
);

  localparam logic [31:0] SeedEff  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  logic [2:0]   pos_q, pos_d;
  logic [31:0]  nucl_q, nucl_d;
  logic [31:0]  lfsr_q, lfsr_d;
  logic [159:0] matrix_q, matrix_d;
  logic [63:0]  lfsr_dbl;

  // Q0.10 matrix for branch k: off-diagonal grows with k, diagonal keeps each row at 1023.
  function automatic logic [159:0] rom_entry(logic [2:0] k);
    logic [159:0] m;
    logic [9:0]   off;
    logic [9:0]   diag;
    off  = 10'(OFFDIAG_STEP * (32'(k) + 32'd1));
    diag = 10'(32'd1023 - 32'd3 * 32'(off));
    m    = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[10*(4*r+c) +: 10] = (r == c) ? diag : off;
      end
    end
    return m;
  endfunction

  // Inverse-CDF draw on row `base`; a draw equal to a cumulative bound goes to the next base.
  function automatic logic [1:0] sample_site(logic [1:0] base, logic [9:0] r, logic [159:0] p);
    int unsigned row;
    logic [10:0] rr;
    logic [10:0] c1;
    logic [10:0] c2;
    logic [10:0] c3;
    logic [1:0]  nb;
    row = 32'(base) * 32'd40;
    rr  = {1'b0, r};
    c1  = {1'b0, p[row +: 10]};
    c2  = c1 + {1'b0, p[row + 10 +: 10]};
    c3  = c2 + {1'b0, p[row + 20 +: 10]};
    if (rr < c1)      nb = 2'd0;
    else if (rr < c2) nb = 2'd1;
    else if (rr < c3) nb = 2'd2;
    else              nb = 2'd3;
    return nb;
  endfunction

  always_comb begin
    pos_d    = pos_q + 3'd1;
    matrix_d = rom_entry(pos_d);
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
    // Doubling the word turns the per-site rotate-right into a plain part-select.
    lfsr_dbl = {lfsr_q, lfsr_q};
    nucl_d   = nucl_q;
    for (int i = 0; i < 16; i++) begin
      nucl_d[2*i +: 2] = sample_site(nucl_q[2*i +: 2], lfsr_dbl[2*i +: 10], matrix_q);
    end
`ifdef CTRL_ROOT_RELOAD_EN
    if (pos_q == 3'd7) nucl_d = ROOT_SEQ;
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q    <= 3'd0;
      nucl_q   <= ROOT_SEQ;
      lfsr_q   <= SeedEff;
      matrix_q <= rom_entry(3'd0);
    end else begin
      pos_q    <= pos_d;
      nucl_q   <= nucl_d;
      lfsr_q   <= lfsr_d;
      matrix_q <= matrix_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.nucl_alig = nucl_q;
  assign bus.matrix_P  = matrix_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: reset values, branch walk, identity P, golden LFSR model,
// asynchronous mid-run reset and the optional root-reload wrap behaviour.
module tb_controller;

  localparam logic [31:0] Root = 32'h1B1B_1B1B;
  localparam logic [31:0] Seed = 32'hACE1_0001;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int bnd_hits  = 0;

  int diag_tab [9] = '{975, 951, 927, 903, 879, 855, 831, 999, 975};
  int off_tab  [9] = '{16, 24, 32, 40, 48, 56, 64, 8, 16};

  controller_if bus ();
  controller_if id_bus ();

  controller #(.OFFDIAG_STEP(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  controller #(.OFFDIAG_STEP(0)) dut_id (
    .clk   (clk),
    .reset (reset),
    .bus   (id_bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [159:0] got, logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] m_rom(int step, int k);
    logic [159:0] m;
    int o;
    int d;
    o = step * (k + 1);
    d = 1023 - 3 * o;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[10*(4*r+c) +: 10] = (r == c) ? 10'(d) : 10'(o);
    return m;
  endfunction

  function automatic logic [31:0] m_lfsr(logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [31:0] m_evolve(logic [31:0] nucl, logic [31:0] l, int step, int k);
    logic [31:0] res;
    logic [9:0]  r;
    int o;
    int d;
    int x;
    int acc;
    int nb;
    bit done;
    o = step * (k + 1);
    d = 1023 - 3 * o;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      x = int'(nucl[2*i +: 2]);
      for (int b = 0; b < 10; b++) r[b] = l[(2*i + b) % 32];
      acc  = 0;
      nb   = 3;
      done = 1'b0;
      for (int c = 0; c < 3; c++) begin
        acc += (c == x) ? d : o;
        if (c == 0 && int'(r) == acc && step != 0) bnd_hits++;
        if (!done && int'(r) < acc) begin
          nb   = c;
          done = 1'b1;
        end
      end
      res[2*i +: 2] = 2'(nb);
    end
    return res;
  endfunction

  // Releases reset (caller is at a negedge) and runs n edges against the model.
  task automatic run(int n, bit walk);
    logic [31:0] ml;
    logic [31:0] mn;
    logic [31:0] zn;
    logic [31:0] nn;
    logic [31:0] zz;
    int mp;
    ml = Seed;
    mn = Root;
    zn = Root;
    mp = 0;
    reset = 1'b1;
    for (int t = 1; t <= n; t++) begin
      @(posedge clk);
      nn = m_evolve(mn, ml, 8, mp);
      zz = m_evolve(zn, ml, 0, mp);
`ifdef CTRL_ROOT_RELOAD_EN
      if (mp == 7) begin
        nn = Root;
        zz = Root;
      end
`endif
      mn = nn;
      zn = zz;
      ml = m_lfsr(ml);
      mp = (mp + 1) % 8;
      @(negedge clk);
      check($sformatf("pos@%0d", t), 160'(bus.pos), 160'(mp));
      check($sformatf("nucl@%0d", t), 160'(bus.nucl_alig), 160'(mn));
      check($sformatf("matrix@%0d", t), bus.matrix_P, m_rom(8, mp));
      if (t <= 20) check($sformatf("ident@%0d", t), 160'(id_bus.nucl_alig), 160'(zn));
      if (walk && t <= 9) begin
        check($sformatf("diag11@%0d", t), 160'(bus.matrix_P[50 +: 10]), 160'(diag_tab[t-1]));
        check($sformatf("off01@%0d", t), 160'(bus.matrix_P[10 +: 10]), 160'(off_tab[t-1]));
      end
      if (mp == 0) begin
`ifdef CTRL_ROOT_RELOAD_EN
        check($sformatf("reload@%0d", t), 160'(bus.nucl_alig), 160'(Root));
`else
        check($sformatf("evolve@%0d", t), 160'(bus.nucl_alig), 160'(mn));
`endif
      end
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_pos"}, 160'(bus.pos), 160'(0));
    check({tag, "_nucl"}, 160'(bus.nucl_alig), 160'(Root));
    check({tag, "_matrix"}, bus.matrix_P, m_rom(8, 0));
    check({tag, "_e00"}, 160'(bus.matrix_P[0 +: 10]), 160'(999));
    check({tag, "_e01"}, 160'(bus.matrix_P[10 +: 10]), 160'(8));
    check({tag, "_id_matrix"}, id_bus.matrix_P, m_rom(0, 0));
    check({tag, "_id_nucl"}, 160'(id_bus.nucl_alig), 160'(Root));
  endtask

  initial begin
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst");

    run(64, 1'b1);

    reset = 1'b0;
    @(negedge clk);
    run(5, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset("async");

    @(negedge clk);
    run(64, 1'b0);

    $display("boundary draws r==c1 seen: %0d", bnd_hits);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
